// File: rtl/angle_sweep_pkg.sv
// angle_sweep_pkg: shared fixed-point angle constants and sweep state encoding
package angle_sweep_pkg;
  typedef enum logic [1:0] {IDLE, RUN, LAST, FIN} sweep_state_t;
  localparam longint unsigned PI_2P30 = 64'd3373259426;
  function automatic int pi_q(input int dec_bits);
    return int'((PI_2P30 + (64'd1 << (29 - dec_bits))) >> (30 - dec_bits));
  endfunction
  function automatic int two_pi_q(input int dec_bits);
    return 2 * pi_q(dec_bits);
  endfunction
endpackage

// File: rtl/angle_sweep.sv
// angle_sweep: emits num_samples angles from -pi stepping by step, wrapped into [-pi, pi)
module angle_sweep
  import angle_sweep_pkg::*;
#(
  parameter int INT_BITS = 2,
  parameter int DEC_BITS = 8,
  parameter int CNT_BITS = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [INT_BITS+DEC_BITS-1:0]      step,
  input  logic [CNT_BITS-1:0]               num_samples,
  output logic signed [INT_BITS+DEC_BITS:0] angle,
  output logic                              angle_valid,
  input  logic                              angle_ready,
  output logic                              wrap,
  output logic                              busy,
  output logic                              done
);
  localparam int W = INT_BITS + DEC_BITS + 1;
  localparam logic signed [W:0] PI_S = (W+1)'(pi_q(DEC_BITS));
  localparam logic signed [W:0] TWO_PI_S = (W+1)'(two_pi_q(DEC_BITS));
  localparam logic signed [W-1:0] NEG_PI = W'(-pi_q(DEC_BITS));
  sweep_state_t state, state_n;
  logic signed [W-1:0] angle_n;
  logic signed [W:0] sum;
  logic [CNT_BITS-1:0] count, count_n;
  logic [W-2:0] step_q, step_n;
  logic wrap_n, xfer, over;
  assign angle_valid = state == RUN || state == LAST;
  assign busy = angle_valid;
  assign done = state == FIN;
  assign xfer = angle_valid && angle_ready;
  // one guard bit beyond the angle width so angle+step cannot overflow before the wrap test
  assign sum = $signed({angle[W-1], angle}) + $signed({2'b00, step_q});
  assign over = sum >= PI_S;
  always_comb begin
    state_n = state;
    angle_n = angle;
    wrap_n = wrap;
    count_n = count;
    step_n = step_q;
    if (abort) state_n = IDLE;
    else if (state == IDLE && start) begin
      step_n = step;
      count_n = num_samples;
      angle_n = NEG_PI;
      wrap_n = 1'b0;
      state_n = num_samples == '0 ? FIN : num_samples == CNT_BITS'(1) ? LAST : RUN;
    end else if (xfer) begin
      angle_n = over ? W'(sum - TWO_PI_S) : W'(sum);
      wrap_n = over;
      count_n = count - CNT_BITS'(1);
      state_n = state == LAST ? FIN : count == CNT_BITS'(2) ? LAST : RUN;
    end else if (state == FIN) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      angle <= '0;
      wrap <= 1'b0;
      count <= '0;
      step_q <= '0;
    end else begin
      state <= state_n;
      angle <= angle_n;
      wrap <= wrap_n;
      count <= count_n;
      step_q <= step_n;
    end
  end
endmodule

// File: tb/tb_angle_sweep.sv
// tb_angle_sweep: randomized scoreboard bench for angle_sweep against a closed-form sweep model
module tb_angle_sweep;
  localparam int PI = 804;
  localparam int TWO_PI = 1608;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [9:0] step = '0;
  logic [15:0] num_samples = '0;
  logic signed [10:0] angle;
  logic angle_valid;
  logic angle_ready = 1'b1;
  logic wrap;
  logic busy;
  logic done;
  int vectors = 0;
  int miscompares = 0;
  int exp_ang[$];
  bit exp_wr[$];
  bit hold = 0;
  int hold_ang;
  bit hold_wr;

  angle_sweep dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .step(step),
    .num_samples(num_samples), .angle(angle), .angle_valid(angle_valid),
    .angle_ready(angle_ready), .wrap(wrap), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // k-th angle is -pi plus (k*step mod 2pi); a wrap happened when the 2pi-multiple count rose
  task automatic push_model(input int st, input int n);
    for (int k = 0; k < n; k++) begin
      exp_ang.push_back(-PI + (k * st) % TWO_PI);
      exp_wr.push_back(k > 0 && (k * st) / TWO_PI != ((k - 1) * st) / TWO_PI);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) hold = 0;
    else begin
      if (hold && angle_valid) begin
        chk("stall_angle", int'(angle), hold_ang);
        chk("stall_wrap", int'(wrap), int'(hold_wr));
      end
      if (angle_valid && angle_ready) begin
        if (exp_ang.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          chk("angle", int'(angle), exp_ang.pop_front());
          chk("wrap", int'(wrap), int'(exp_wr.pop_front()));
        end
      end
      hold = angle_valid && !angle_ready;
      hold_ang = int'(angle);
      hold_wr = wrap;
    end
  end

  // mode 0: ready high, 1: random ready, 2: ready low for cycles 3-5
  task automatic sweep(input int st, input int n, input int mode);
    int lat = -1;
    int stalls = 0;
    int bound = 10 * n + 50;
    push_model(st, n);
    @(posedge clk); #1;
    start = 1'b1;
    step = 10'(st);
    num_samples = 16'(n);
    angle_ready = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
      if (angle_valid && !angle_ready) stalls++;
      if (n == 0) chk("zero_idle", int'(angle_valid || busy), 0);
      @(posedge clk); #1;
      start = busy && $urandom_range(0, 3) == 0;
      if (busy) begin
        step = 10'($urandom);
        num_samples = 16'($urandom);
      end
      angle_ready = mode == 0 ? 1'b1 : mode == 2 ? !(i + 1 >= 3 && i + 1 <= 5) : $urandom_range(0, 2) != 0;
    end
    start = 1'b0;
    chk("done_latency", lat, n == 0 ? 1 : n + 1 + stalls);
    if (mode == 2) chk("stall_cycles", stalls, 3);
    chk("queue_drained", exp_ang.size(), 0);
    @(posedge clk); #1;
    angle_ready = 1'b1;
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_valid", int'(angle_valid), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_angle", int'(angle), 0);
    chk("rst_valid", int'(angle_valid), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    sweep(256, 8, 0);
    sweep(256, 8, 2);
    sweep(100, 0, 0);
    sweep(0, 5, 1);
    sweep(1023, 12, 1);
    sweep(804, 6, 0);
    sweep(300, 1, 0);
    // abort after the third transfer, then restart
    begin
      int xfers = 0;
      push_model(256, 20);
      @(posedge clk); #1;
      start = 1'b1;
      step = 10'd256;
      num_samples = 16'd20;
      for (int i = 0; i < 40 && xfers < 3; i++) begin
        @(negedge clk);
        if (angle_valid && angle_ready) xfers++;
        @(posedge clk); #1;
        start = 1'b0;
      end
      chk("abort_xfers", xfers, 3);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_valid", int'(angle_valid), 0);
      chk("abort_busy", int'(busy), 0);
      exp_ang.delete();
      exp_wr.delete();
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("abort_no_done", int'(done), 0);
      end
    end
    sweep(256, 4, 0);
    // asynchronous reset between edges, mid-sweep
    push_model(256, 10);
    @(posedge clk); #1;
    start = 1'b1;
    step = 10'd256;
    num_samples = 16'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_angle", int'(angle), 0);
    chk("arst_valid", int'(angle_valid), 0);
    chk("arst_wrap", int'(wrap), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    exp_ang.delete();
    exp_wr.delete();
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    sweep(256, 3, 0);
    for (int r = 0; r < 20; r++)
      sweep(int'($urandom_range(0, 1023)), int'($urandom_range(0, 30)), int'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/angle_sweep.md
ANGLE_SWEEP -- requirements
Module: angle_sweep

Interface
REQ-001 SHALL have parameter INT_BITS, default 2, integer bits of the angle magnitude.
REQ-002 SHALL have parameter DEC_BITS, default 8, fractional bits of the angle.
REQ-003 SHALL have parameter CNT_BITS, default 16, width of the sample counter.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  begin a sweep; sampled only in IDLE.
REQ-007 SHALL have port abort  in  1  terminate the sweep without done.
REQ-008 SHALL have port step  in  INT_BITS+DEC_BITS  unsigned angle increment, Q(INT_BITS).(DEC_BITS).
REQ-009 SHALL have port num_samples  in  CNT_BITS  beats to emit, unsigned.
REQ-010 SHALL have port angle  out  INT_BITS+DEC_BITS+1  signed two's-complement angle, same format as the cosine stage input x.
REQ-011 SHALL have port angle_valid  out  1  angle holds a beat.
REQ-012 SHALL have port angle_ready  in  1  downstream accepts the beat.
REQ-013 SHALL have port wrap  out  1  current beat's angle resulted from a wrap; qualified by angle_valid.
REQ-014 SHALL have port busy  out  1  high in RUN and LAST.
REQ-015 SHALL have port done  out  1  one-cycle pulse at normal sweep completion.

Function
REQ-016 SHALL define PI_Q = round(pi * 2^DEC_BITS) (804 at DEC_BITS=8) and TWO_PI_Q = 2*PI_Q.
REQ-017 SHALL implement states IDLE, RUN, LAST, FIN.
REQ-018 IDLE + start + num_samples != 0 SHALL latch step, load angle = -PI_Q, load count = num_samples, enter RUN; angle_valid high the next cycle.
REQ-019 IDLE + start + num_samples == 0 SHALL enter FIN, never asserting angle_valid.
REQ-020 RUN/LAST SHALL hold angle_valid high; a beat transfers when angle_valid && angle_ready.
REQ-021 While angle_valid && !angle_ready, angle, wrap and count SHALL hold stable.
REQ-022 On each transfer: sum = angle + step computed at INT_BITS+DEC_BITS+2 bits; if sum >= PI_Q, angle = sum - TWO_PI_Q and wrap = 1, else angle = sum and wrap = 0; count decrements.
REQ-023 Angle SHALL always stay within [-PI_Q, PI_Q-1]; step > TWO_PI_Q is unsupported, and step = 0 emits constant -PI_Q.
REQ-024 RUN SHALL enter LAST when count reaches 1; transfer in LAST SHALL enter FIN with angle_valid low the next cycle.
REQ-025 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-026 start SHALL be ignored in RUN, LAST, FIN; step and num_samples changes there have no effect.
REQ-027 abort in any state SHALL enter IDLE next cycle, angle_valid low, no done; abort has priority over start and over a simultaneous transfer.
REQ-028 Throughput SHALL be one beat per cycle with angle_ready held high.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, angle 0, angle_valid 0, wrap 0, busy 0, done 0, count 0, latched step 0, including mid-sweep.
REQ-030 After rst_n rises, the first start SHALL be honoured on the first clk edge.

Structure
REQ-031 PI_Q/TWO_PI_Q functions and the state enumeration SHALL live in a shared fixed-point package used also by the cosine stage.
REQ-032 SHALL be a single module with no sub-module; the cosine stage connects outside it.

Verification
REQ-033 Defaults, start, step=256, num_samples=8, ready=1 -> angles -804,-548,-292,-36,220,476,732,-620 (wrap=1 on last only), done one cycle after the 8th transfer.
REQ-034 Same sweep, angle_ready low for cycles 3-5 -> angle holds -292 through the stall, sequence otherwise unchanged, done delayed 3 cycles.
REQ-035 start with num_samples=0 -> angle_valid never high, done pulses one cycle later, busy stays 0.
REQ-036 abort after 3rd transfer -> angle_valid low next cycle, no done, busy 0; a new start then restarts at -804.
REQ-037 start pulsed while busy -> ignored, sequence unchanged.
REQ-038 rst_n low mid-sweep between clk edges -> all outputs 0 immediately; next start yields -804 first.
